// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE   = 4'h9;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned calc_maxv(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Pre-shift correction so the following doubling carries cleanly into the next digit.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADJ_THRESH) begin
      digit_out = digit_in + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// feeding the 7-segment driver; the result is held between conversions.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(IN_W + 1);
  localparam int unsigned MAXV  = calc_maxv(DIGITS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [IN_W-1:0]    bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shift;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic               accept;
  logic               last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  // The top input bit enters the least significant BCD bit; high BCD bits
  // that fall off the top are only possible when ovf_pend is already set.
  assign scratch_shift = {scratch_adj[BCD_W-2:0], bin_sr[IN_W-1]};

  // State register; an asynchronous reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_shift = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_ONE) begin
          last_shift = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift-and-add while converting, and publish
  // the result on the final shift edge so it is visible together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd_out  <= '0;
      ovf      <= 1'b0;
    end else if (accept) begin
      bin_sr   <= bin_in;
      scratch  <= '0;
      cnt      <= CNT_INIT;
      ovf_pend <= (64'(bin_in) > 64'(MAXV));
    end else if (state == SHIFT) begin
      scratch <= scratch_shift;
      bin_sr  <= {bin_sr[IN_W-2:0], 1'b0};
      cnt     <= cnt - CNT_ONE;
      if (last_shift) begin
        bcd_out <= ovf_pend ? {DIGITS{BCD_NINE}} : scratch_shift;
        ovf     <= ovf_pend;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed, table-driven self-checking bench for bin2bcd_seq.
module tb_bin2bcd_seq;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int          checks = 0;
  int          errors = 0;
  int          cycles;
  int          hold_err;
  int          done_seen;
  logic [15:0] held;
  vec_t        vecs[8];

  bin2bcd_seq #(.IN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Decimal reference, saturating at 9999.
  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One full conversion from IDLE; bin_in is scrambled while busy.
  task automatic applyStimulus(input logic [13:0] value, input logic [15:0] exp_bcd,
                               input logic exp_ovf, input string name);
    int n;
    int busy_err;
    int herr;
    logic [15:0] h;
    start  = 1'b1;
    bin_in = value;
    stepCycle();
    start  = 1'b0;
    bin_in = ~value;
    h = bcd_out;
    n = 0;
    busy_err = 0;
    herr = 0;
    while (!done && n < 40) begin
      if (!busy) busy_err++;
      if (bcd_out !== h) herr++;
      stepCycle();
      n++;
    end
    checkOutput({name, " latency"}, 32'(n), 32'd14);
    checkOutput({name, " busy"}, 32'(busy_err), 32'd0);
    checkOutput({name, " hold"}, 32'(herr), 32'd0);
    checkOutput({name, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
    checkOutput({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
    checkOutput({name, " busy at done"}, 32'(busy), 32'd1);
    stepCycle();
    checkOutput({name, " done pulse"}, 32'(done), 32'd0);
    checkOutput({name, " idle"}, 32'(busy), 32'd0);
    checkOutput({name, " bcd kept"}, 32'(bcd_out), 32'(exp_bcd));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd255,   16'h0255, 1'b0};
    vecs[4] = '{14'd10000, 16'h9999, 1'b1};
    vecs[5] = '{14'd16383, 16'h9999, 1'b1};
    vecs[6] = '{14'd42,    16'h0042, 1'b0};
    vecs[7] = '{14'd7,     16'h0007, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset bcd", 32'(bcd_out), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Start held high: back-to-back conversions, one every 16 cycles.
    start  = 1'b1;
    bin_in = 14'd0;
    for (int v = 0; v <= 20; v++) begin
      if (v > 0) begin
        stepCycle();
        checkOutput("stream gap idle", 32'(busy), 32'd0);
      end
      stepCycle();
      checkOutput("stream accept busy", 32'(busy), 32'd1);
      bin_in   = 14'(16383 - v);
      held     = bcd_out;
      cycles   = 0;
      hold_err = 0;
      while (!done && cycles < 40) begin
        if (bcd_out !== held) hold_err++;
        stepCycle();
        cycles++;
      end
      checkOutput("stream latency", 32'(cycles), 32'd14);
      checkOutput("stream hold", 32'(hold_err), 32'd0);
      checkOutput("stream bcd", 32'(bcd_out), 32'(to_bcd(v)));
      checkOutput("stream ovf", 32'(ovf), 32'd0);
      bin_in = 14'(v + 1);
    end
    start = 1'b0;
    stepCycle();
    checkOutput("stream end idle", 32'(busy), 32'd0);

    // Starts during SHIFT and during DONE are ignored.
    start  = 1'b1;
    bin_in = 14'd500;
    stepCycle();
    start  = 1'b0;
    cycles = 1;
    repeat (3) begin stepCycle(); cycles++; end
    start  = 1'b1;
    bin_in = 14'd700;
    stepCycle();
    cycles++;
    start  = 1'b0;
    while (!done && cycles < 40) begin stepCycle(); cycles++; end
    checkOutput("ignore latency", 32'(cycles), 32'd15);
    checkOutput("ignore bcd", 32'(bcd_out), 32'h0500);
    start  = 1'b1;
    bin_in = 14'd700;
    stepCycle();
    start  = 1'b0;
    checkOutput("ignore done-cycle start idle", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("ignore not queued", 32'(busy), 32'd0);
    checkOutput("ignore bcd kept", 32'(bcd_out), 32'h0500);

    // Asynchronous reset mid-conversion.
    applyStimulus(14'd321, 16'h0321, 1'b0, "pre-reset");
    start  = 1'b1;
    bin_in = 14'd999;
    stepCycle();
    start  = 1'b0;
    repeat (6) stepCycle();
    checkOutput("mid busy", 32'(busy), 32'd1);
    checkOutput("mid bcd held", 32'(bcd_out), 32'h0321);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async done", 32'(done), 32'd0);
    checkOutput("async bcd", 32'(bcd_out), 32'd0);
    checkOutput("async ovf", 32'(ovf), 32'd0);
    stepCycle();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      stepCycle();
      if (done || busy) done_seen++;
    end
    checkOutput("no done after abort", 32'(done_seen), 32'd0);
    applyStimulus(14'd4321, 16'h4321, 1'b0, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
